// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter for a single-ported 16-bit byte-addressable memory.
// Optional feature: define MEM_ARB_RR_EN to replace data-first priority with round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_grant,
  output logic                  if_done,
  output logic [15:0]           if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [15:0]           dm_wdata,
  output logic                  dm_grant,
  output logic                  dm_done,
  output logic [15:0]           dm_rdata,
  output logic                  dm_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  mem_enable,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_if_q, owner_if_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  if_grant_q, if_grant_d;
  logic                  dm_grant_q, dm_grant_d;
  logic [15:0]           if_rdata_q, if_rdata_d;
  logic [15:0]           dm_rdata_q, dm_rdata_d;
  logic                  if_err_q, if_err_d;
  logic                  dm_err_q, dm_err_d;
  logic                  pick_if;
  logic                  last_busy;
  logic                  misaligned;
`ifdef MEM_ARB_RR_EN
  logic                  last_if_q, last_if_d;
`else
  logic [7:0]            starve_q, starve_d;
`endif

  assign misaligned = addr_q[0];
  assign last_busy  = (state_q == BUSY) && (cnt_q == 4'd0);

  // Tie-break: round-robin favours the port that lost last time.
`ifdef MEM_ARB_RR_EN
  assign pick_if = if_req && (!dm_req || !last_if_q);
`else
  assign pick_if = if_req && (!dm_req || (starve_q == 8'(STARVE_MAX)));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_if_d = owner_if_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_grant_d = 1'b0;
    dm_grant_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_err_d   = 1'b0;
    dm_err_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_if_d  = last_if_q;
`else
    starve_d   = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_if_d = pick_if;
          cnt_d      = CNT_LOAD;
          state_d    = BUSY;
          if (pick_if) begin
            addr_d     = if_addr;
            wr_d       = 1'b0;
            wdata_d    = 16'h0000;
            if_grant_d = 1'b1;
`ifdef MEM_ARB_RR_EN
            last_if_d  = 1'b1;
`else
            starve_d   = 8'd0;
`endif
          end else begin
            addr_d     = dm_addr;
            wr_d       = dm_wr;
            wdata_d    = dm_wdata;
            dm_grant_d = 1'b1;
`ifdef MEM_ARB_RR_EN
            last_if_d  = 1'b0;
`else
            if (if_req && (starve_q < 8'(STARVE_MAX))) starve_d = starve_q + 8'd1;
`endif
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (owner_if_q) begin
            if_rdata_d = misaligned ? 16'h0000 : mem_rdata;
            if_err_d   = misaligned;
          end else begin
            dm_rdata_d = (misaligned || wr_q) ? 16'h0000 : mem_rdata;
            dm_err_d   = misaligned;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_if_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      if_grant_q <= 1'b0;
      dm_grant_q <= 1'b0;
      if_rdata_q <= 16'h0000;
      dm_rdata_q <= 16'h0000;
      if_err_q   <= 1'b0;
      dm_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_if_q  <= 1'b0;
`else
      starve_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_if_q <= owner_if_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_grant_q <= if_grant_d;
      dm_grant_q <= dm_grant_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_err_q   <= if_err_d;
      dm_err_q   <= dm_err_d;
`ifdef MEM_ARB_RR_EN
      last_if_q  <= last_if_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  // Gating with rst keeps a write from landing in the cycle reset is asserted.
  assign mem_enable = last_busy && !misaligned && !rst;
  assign mem_wr     = mem_enable && wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_grant   = if_grant_q;
  assign dm_grant   = dm_grant_q;
  assign if_done    = (state_q == DONE) && owner_if_q;
  assign dm_done    = (state_q == DONE) && !owner_if_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_err     = if_err_q;
  assign dm_err     = dm_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses LATENCY=1, instance 1 uses LATENCY=3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        if_req    [2];
  logic [15:0] if_addr   [2];
  logic        if_grant  [2];
  logic        if_done   [2];
  logic [15:0] if_rdata  [2];
  logic        if_err    [2];
  logic        dm_req    [2];
  logic        dm_wr     [2];
  logic [15:0] dm_addr   [2];
  logic [15:0] dm_wdata  [2];
  logic        dm_grant  [2];
  logic        dm_done   [2];
  logic [15:0] dm_rdata  [2];
  logic        dm_err    [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_enable[2];
  logic        mem_wr    [2];
  logic [15:0] mem [2][256];
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(g == 0 ? 1 : 3), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_grant(if_grant[g]),
      .if_done(if_done[g]), .if_rdata(if_rdata[g]), .if_err(if_err[g]),
      .dm_req(dm_req[g]), .dm_wr(dm_wr[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_grant(dm_grant[g]), .dm_done(dm_done[g]), .dm_rdata(dm_rdata[g]), .dm_err(dm_err[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .mem_enable(mem_enable[g]), .mem_wr(mem_wr[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int j = 0; j < 256; j++) mem[i][j] <= 16'h0000;
      end else if (mem_enable[i] && mem_wr[i]) begin
        mem[i][mem_addr[i][8:1]] <= mem_wdata[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][mem_addr[i][8:1]];
  end

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } txn_t;

  txn_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  task automatic run_txn(input int d, input int lat, input txn_t t);
    int   cyc;
    int   en_cnt;
    int   wr_cnt;
    logic mis;
    mis = t.addr[0];
    if (t.fetch) begin
      if_req[d]  = 1'b1;
      if_addr[d] = t.addr;
    end else begin
      dm_req[d]   = 1'b1;
      dm_wr[d]    = t.wr;
      dm_addr[d]  = t.addr;
      dm_wdata[d] = t.wdata;
    end
    @(posedge clk);
    #1;
    chk("grant", {30'd0, if_grant[d], dm_grant[d]}, t.fetch ? 32'd2 : 32'd1);
    chk("mem_addr", {16'd0, mem_addr[d]}, {16'd0, t.addr});
    if (lat == 1) chk("grant_cycle_enable", {31'd0, mem_enable[d]}, {31'd0, !mis});
    cyc = 0; en_cnt = 0; wr_cnt = 0;
    while (!(if_done[d] || dm_done[d]) && cyc < 40) begin
      en_cnt += int'(mem_enable[d]);
      wr_cnt += int'(mem_wr[d]);
      @(posedge clk);
      #1;
      cyc++;
    end
    if_req[d] = 1'b0;
    dm_req[d] = 1'b0;
    chk("done_latency", cyc, lat);
    chk("done_port", {30'd0, if_done[d], dm_done[d]}, t.fetch ? 32'd2 : 32'd1);
    chk("rdata", {16'd0, (t.fetch ? if_rdata[d] : dm_rdata[d])}, {16'd0, t.exp_rdata});
    chk("err", {31'd0, (t.fetch ? if_err[d] : dm_err[d])}, {31'd0, t.exp_err});
    chk("enable_count", en_cnt, mis ? 0 : 1);
    chk("wr_count", wr_cnt, (!t.fetch && t.wr && !mis) ? 1 : 0);
    @(posedge clk);
    #1;
    chk("err_after_done", {30'd0, if_err[d], dm_err[d]}, 32'd0);
  endtask

  initial begin
    int   ng;
    int   cyc;
    int   overlap;
    int   wrs;
    int   dones;
    logic [1:0] order [10];
    logic [1:0] exp_order [10];
    txn_t t;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = 16'h0000;
      dm_req[i] = 1'b0; dm_wr[i] = 1'b0; dm_addr[i] = 16'h0000; dm_wdata[i] = 16'h0000;
    end
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    chk("reset_ctrl", {26'd0, if_grant[0], dm_grant[0], if_done[0], dm_done[0],
                       mem_enable[0], mem_wr[0]}, 32'd0);
    chk("reset_data", {if_rdata[0], dm_rdata[0]}, 32'd0);
    chk("reset_mem", {mem_addr[0], mem_wdata[0]}, 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    //          fetch wr    addr      wdata     rdata     err
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'hFFFE, 16'h1234, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h1234, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h1234, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0013, 16'h5555, 16'h0000, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 16'h0000, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    for (int i = 0; i < 9; i++) run_txn(0, 1, tbl[i]);
    chk("if_rdata_held", {16'd0, if_rdata[0]}, 32'h0);

    // Arbitration with both requesters held high from a fresh reset.
    do_reset(0);
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 10; i++) exp_order[i] = (i % 2 == 0) ? 2'd1 : 2'd2;
`else
    for (int i = 0; i < 10; i++) exp_order[i] = (i == 4 || i == 9) ? 2'd1 : 2'd2;
`endif
    for (int i = 0; i < 10; i++) order[i] = 2'd0;
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    dm_req[0] = 1'b1; dm_wr[0] = 1'b0; dm_addr[0] = 16'h0002;
    ng = 0; cyc = 0; overlap = 0;
    while (ng < 10 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (if_grant[0]) begin order[ng] = 2'd1; ng++; end
      else if (dm_grant[0]) begin order[ng] = 2'd2; ng++; end
      if ((if_done[0] || dm_done[0]) && mem_enable[0]) overlap++;
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    for (int i = 0; i < 10; i++) chk($sformatf("grant_order_%0d", i), {30'd0, order[i]}, {30'd0, exp_order[i]});
    chk("done_enable_overlap", overlap, 0);
    repeat (4) @(posedge clk);
    #1;

    // LATENCY=3: seed a word, read it back, then reset in the middle of an overwrite.
    t = '{1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0};
    run_txn(1, 3, t);
    t = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};
    run_txn(1, 3, t);
    dm_req[1] = 1'b1; dm_wr[1] = 1'b1; dm_addr[1] = 16'h0020; dm_wdata[1] = 16'h2222;
    wrs = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_grant", {31'd0, dm_grant[1]}, 32'd1);
    wrs += int'(mem_wr[1]);
    @(posedge clk);
    #1;
    wrs += int'(mem_wr[1]);
    rst[1] = 1'b1;
    dm_req[1] = 1'b0;
    #2;
    wrs += int'(mem_wr[1]);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    chk("rst_after_ctrl", {26'd0, if_grant[1], dm_grant[1], if_done[1], dm_done[1],
                           mem_enable[1], mem_wr[1]}, 32'd0);
    chk("rst_after_data", {if_rdata[1], dm_rdata[1]}, 32'd0);
    chk("rst_after_mem", {mem_addr[1], mem_wdata[1]}, 32'd0);
    chk("rst_after_err", {30'd0, if_err[1], dm_err[1]}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      dones += int'(dm_done[1]);
      wrs   += int'(mem_wr[1]);
      @(posedge clk);
      #1;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_no_write", wrs, 0);
    chk("rst_word_kept", {16'd0, mem[1][16]}, 32'h1111);

    t = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
    run_txn(1, 3, t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
